// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg
//   Shared definitions for the bit-serial adder controller: the FSM state
//   encoding and the legal-range test for the operand width.
//   No ports; imported with "import serial_add_ctrl_pkg::*;".

`ifndef SERIAL_ADD_CTRL_WIDTH_LEGAL
`define SERIAL_ADD_CTRL_WIDTH_LEGAL(w) (((w) >= 2) && ((w) <= 32))
`endif

package serial_add_ctrl_pkg;

  // Controller states. Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when w is an operand width the serial engine supports.
  function automatic bit widthLegal(input int w);
    return `SERIAL_ADD_CTRL_WIDTH_LEGAL(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fulladd.sv
// fulladd
//   One-bit full adder cell, purely combinational.
//   Ports:
//     Cin  in  1  carry in
//     x    in  1  addend bit
//     y    in  1  addend bit
//     s    out 1  sum bit
//     Cout out 1  carry out

module fulladd (
  input  logic Cin,
  input  logic x,
  input  logic y,
  output logic s,
  output logic Cout
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    s    = x ^ y ^ Cin;
    Cout = (x & y) | (x & Cin) | (y & Cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder: accepts two WIDTH-bit operands and a carry-in, then adds
//   them LSB-first through a single fulladd cell, one bit per clock, with a
//   registered carry. The result is offered behind a valid/ready handshake.
//   Ports:
//     clk       in   1      clock, rising edge
//     rst       in   1      synchronous active-high reset
//     in_valid  in   1      operands valid
//     in_ready  out  1      ready for operands (IDLE only)
//     a, b      in   WIDTH  operands, sampled on accept
//     cin       in   1      carry-in, sampled on accept
//     out_valid out  1      result valid (DONE only)
//     out_ready in   1      consumer takes the result
//     sum       out  WIDTH  registered sum
//     cout      out  1      registered carry-out
//     busy      out  1      addition in progress (RUN)

module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  if (!widthLegal(WIDTH)) begin : gWidthCheck
    $error("serial_add_ctrl: WIDTH must lie in 2..32");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] sumShift_q, sumShift_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic faSum;
  logic faCout;
  logic lastBit;
  logic [WIDTH-1:0] sumShifted;

  // The single adder cell always looks at the current LSBs and stored carry.
  fulladd uFullAdd (
    .Cin  (carry_q),
    .x    (aShift_q[0]),
    .y    (bShift_q[0]),
    .s    (faSum),
    .Cout (faCout)
  );

  // The counter never wraps: RUN leaves on the bit whose index is WIDTH-1.
  assign lastBit    = (count_q == CNT_W'(WIDTH - 1));
  assign sumShifted = {faSum, sumShift_q[WIDTH-1:1]};

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Unused encodings fall back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = in_valid  ? ST_RUN  : ST_IDLE;
      ST_RUN:  state_d = lastBit   ? ST_DONE : ST_RUN;
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs are pure decodes of the state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN);
  end

  // Datapath next values. Operands load on accept; each RUN cycle shifts one
  // sum bit in at the MSB so that after WIDTH shifts bit 0 holds the first
  // sum bit. The visible sum/cout only change on the final RUN cycle, so the
  // previous result stays on the outputs while a new addition is running.
  always_comb begin
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    sumShift_d = sumShift_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          aShift_d = a;
          bShift_d = b;
          carry_d  = cin;
          count_d  = '0;
        end
      end
      ST_RUN: begin
        aShift_d   = aShift_q >> 1;
        bShift_d   = bShift_q >> 1;
        sumShift_d = sumShifted;
        carry_d    = faCout;
        count_d    = count_q + CNT_W'(1);
        if (lastBit) begin
          sum_d  = sumShifted;
          cout_d = faCout;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything, discarding any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      aShift_q   <= '0;
      bShift_q   <= '0;
      sumShift_q <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      sumShift_q <= sumShift_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cout_q     <= cout_d;
      count_q    <= count_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl at WIDTH=8. Expected results are
//   computed from a+b+cin and queued when operands are offered; a monitor pops
//   and compares them whenever the DUT hands a result over.

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } result_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  result_t expQ[$];
  int      compareCount;
  int      mismatchCount;
  int      cycle;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure the spacing between accepts.
  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference model: the full-width sum of the operands and carry-in.
  function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic c);
    logic [WIDTH:0] full;
    result_t r;
    full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    return r;
  endfunction

  // Monitor: a result handed over in this cycle is compared with the oldest
  // queued expectation. Sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    result_t e;
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sum", {24'd0, sum}, {24'd0, e.sum});
        checkOutput("cout", {31'd0, cout}, {31'd0, e.cout});
      end
    end
  end

  // Wait (from #1 after an edge) until in_ready is high, with a cycle bound.
  task automatic waitReady();
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // One complete transaction: offer operands, measure latency to out_valid,
  // optionally hold the result under backpressure while poking new operands,
  // then accept it. Starts and ends at #1 after a rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                               input logic opCin, input int holdCycles);
    int edges;
    result_t e;
    waitReady();
    e = model(opA, opB, opCin);
    a = opA; b = opB; cin = opCin; in_valid = 1'b1;
    expQ.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    // The accept edge counts as the first one.
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("latency_edges", edges, WIDTH + 1);
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("hold_sum", {24'd0, sum}, {24'd0, e.sum});
      checkOutput("hold_cout", {31'd0, cout}, {31'd0, e.cout});
      in_valid = ~in_valid;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idle_after_take", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lastAccept;
    int n;
    result_t e;

    compareCount  = 0;
    mismatchCount = 0;
    cycle         = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_sum", {24'd0, sum}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic additions");
    applyStimulus(8'h0F, 8'h01, 1'b0, 0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
    applyStimulus(8'h00, 8'h00, 1'b0, 0);

    $display("[TB] backpressure");
    applyStimulus(8'h3C, 8'h5A, 1'b1, 5);

    $display("[TB] reset during RUN");
    // Previous result 0x3C+0x5A+1 = 0x97 is on sum; reset must clear it.
    waitReady();
    a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_sum", {24'd0, sum}, 32'd0);
    applyStimulus(8'h55, 8'hAA, 1'b0, 0);

    $display("[TB] back-to-back");
    out_ready  = 1'b1;
    lastAccept = 0;
    for (int i = 0; i < 20; i++) begin
      waitReady();
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      in_valid = 1'b1;
      expQ.push_back(model(a, b, cin));
      @(posedge clk); #1;
      if (i > 0) checkOutput("accept_spacing", cycle - lastAccept, 32'd10);
      lastAccept = cycle;
    end
    in_valid = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("queue_drained", expQ.size(), 32'd0);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
